// File: rtl/alu_exec_if.sv
// alu_exec_if: request/response bundle between the issue side and alu_exec.
// Issue side drives the request; alu_exec returns status and results.
interface alu_exec_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       alu_ctrl;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [4:0]       shamt;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] hi;
  logic             zero;
  logic             div_by_zero;

  modport master (
    output start, alu_ctrl, a, b, shamt,
    input  busy, done, result, hi, zero, div_by_zero
  );

  modport slave (
    input  start, alu_ctrl, a, b, shamt,
    output busy, done, result, hi, zero, div_by_zero
  );
endinterface

// File: rtl/alu_exec.sv
// alu_exec: execute-stage ALU with single-cycle ops and
// iterative shift-add multiply / restoring divide.
module alu_exec #(
  parameter int WIDTH = 32
) (
  input logic      clk,
  input logic      rst_n,
  alu_exec_if.slave bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] acc_hi_q;
  logic [WIDTH-1:0] acc_lo_q;
  logic [WIDTH-1:0] opd_q;

  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] hi_q;
  logic             zero_q;
  logic             dbz_q;

  logic op_and, op_or, op_add, op_sub, op_slt;
  logic op_sll, op_srl, op_not, op_mul, op_div;

  logic [WIDTH-1:0] sc_res;
  logic [WIDTH-1:0] sc_hi;
  logic             sc_dbz;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi;
  logic [WIDTH-1:0] mul_lo;
  logic [WIDTH:0]   div_tr;
  logic [WIDTH:0]   div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] div_hi;
  logic [WIDTH-1:0] div_lo;

  logic [WIDTH-1:0] nxt_hi;
  logic [WIDTH-1:0] nxt_lo;

  logic             accept;
  logic             fin;
  logic             last;
  logic             done_d;
  logic [WIDTH-1:0] out_res;
  logic [WIDTH-1:0] out_hi;
  logic             out_dbz;

  assign last = (cnt_q == CW'(WIDTH - 1));

  // One-hot decode of the operation code
  always_comb begin
    op_and = 1'b0;
    op_or  = 1'b0;
    op_add = 1'b0;
    op_sub = 1'b0;
    op_slt = 1'b0;
    op_sll = 1'b0;
    op_srl = 1'b0;
    op_not = 1'b0;
    op_mul = 1'b0;
    op_div = 1'b0;
    unique case (1'b1)
      (bus.alu_ctrl == 4'b0000): op_and = 1'b1;
      (bus.alu_ctrl == 4'b0001): op_or  = 1'b1;
      (bus.alu_ctrl == 4'b0010): op_add = 1'b1;
      (bus.alu_ctrl == 4'b0110): op_sub = 1'b1;
      (bus.alu_ctrl == 4'b0111): op_slt = 1'b1;
      (bus.alu_ctrl == 4'b0101): op_sll = 1'b1;
      (bus.alu_ctrl == 4'b1000): op_srl = 1'b1;
      (bus.alu_ctrl == 4'b1001): op_not = 1'b1;
      (bus.alu_ctrl == 4'b1111): op_mul = 1'b1;
      (bus.alu_ctrl == 4'b0011): op_div = 1'b1;
      default: ;
    endcase
  end

  // Single-cycle result; divide-by-zero also resolves here
  always_comb begin
    sc_res = '0;
    sc_hi  = '0;
    sc_dbz = 1'b0;
    unique case (1'b1)
      op_and: sc_res = bus.a & bus.b;
      op_or:  sc_res = bus.a | bus.b;
      op_add: sc_res = bus.a + bus.b;
      op_sub: sc_res = bus.a - bus.b;
      op_slt: sc_res = WIDTH'($signed(bus.a) < $signed(bus.b));
      op_sll: sc_res = bus.a << bus.shamt;
      op_srl: sc_res = bus.a >> bus.shamt;
      op_not: sc_res = ~bus.a;
      op_div: begin
        sc_res = '1;
        sc_hi  = bus.a;
        sc_dbz = 1'b1;
      end
      default: ;
    endcase
  end

  // One iteration step for multiply and divide
  always_comb begin
    mul_sum  = {1'b0, acc_hi_q}
             + (acc_lo_q[0] ? {1'b0, opd_q} : '0);
    mul_hi   = mul_sum[WIDTH:1];
    mul_lo   = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
    div_tr   = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_diff = div_tr - {1'b0, opd_q};
    div_ge   = (div_tr >= {1'b0, opd_q});
    div_hi   = div_ge ? div_diff[WIDTH-1:0]
                      : div_tr[WIDTH-1:0];
    div_lo   = {acc_lo_q[WIDTH-2:0], div_ge};
    nxt_hi   = (state_q == S_MUL) ? mul_hi : div_hi;
    nxt_lo   = (state_q == S_MUL) ? mul_lo : div_lo;
  end

  // Next-state logic and done/output selection
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    fin     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          accept = 1'b1;
          if (op_mul) begin
            state_d = S_MUL;
          end else if (op_div && (bus.b != '0)) begin
            state_d = S_DIV;
          end
        end
      end
      S_MUL, S_DIV: begin
        if (last) begin
          state_d = S_IDLE;
          fin     = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    done_d  = fin || (accept && (state_d == S_IDLE));
    out_res = fin ? nxt_lo : sc_res;
    out_hi  = fin ? nxt_hi : sc_hi;
    out_dbz = fin ? 1'b0 : sc_dbz;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand latch, iteration registers and result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opd_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      hi_q     <= '0;
      zero_q   <= 1'b1;
      dbz_q    <= 1'b0;
    end else begin
      busy_q <= (state_d != S_IDLE);
      done_q <= done_d;
      if (accept) begin
        cnt_q    <= '0;
        acc_hi_q <= '0;
        acc_lo_q <= op_mul ? bus.b : bus.a;
        opd_q    <= op_mul ? bus.a : bus.b;
      end else if (state_q != S_IDLE) begin
        cnt_q    <= cnt_q + CW'(1);
        acc_hi_q <= nxt_hi;
        acc_lo_q <= nxt_lo;
      end
      if (done_d) begin
        result_q <= out_res;
        hi_q     <= out_hi;
        zero_q   <= (out_res == '0);
        dbz_q    <= out_dbz;
      end
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.result      = result_q;
  assign bus.hi          = hi_q;
  assign bus.zero        = zero_q;
  assign bus.div_by_zero = dbz_q;

endmodule
